// File: rtl/lc4_mul_seq.sv
// lc4_mul_seq
//   Multi-cycle shift-and-add multiplier controller. It has no adder of its own.
//   Instead it drives the shared combinational lc4 ALU with CHECK, ADD and SDR2
//   instructions. It captures i_alu_result on the next rising edge to build a
//   2*WORD_SIZE unsigned product in {hi, lo}.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_start               request, accepted only in IDLE or DONE
//   i_a, i_b              multiplicand / multiplier, latched on accept
//   o_busy                high while iterating (CHECK/ADD/SHH/SHL)
//   o_done                one-cycle completion pulse
//   o_prod_hi, o_prod_lo  product words, held until the next accept
//   o_alu_insn            instruction to the ALU
//   o_alu_r1data          ALU operand r1
//   o_alu_r2data          ALU operand r2
//   o_alu_carry           ALU carry input
//   i_alu_result          ALU result
module lc4_mul_seq #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WORD_SIZE-1:0] o_prod_hi,
  output logic [WORD_SIZE-1:0] o_prod_lo,
  output logic [15:0]          o_alu_insn,
  output logic [WORD_SIZE-1:0] o_alu_r1data,
  output logic [WORD_SIZE-1:0] o_alu_r2data,
  output logic                 o_alu_carry,
  input  logic [WORD_SIZE-1:0] i_alu_result
);

  localparam logic [15:0] INSN_NOP   = 16'h0000;
  localparam logic [15:0] INSN_ADD   = 16'h1000;
  localparam logic [15:0] INSN_CHECK = 16'h1008;
  localparam logic [15:0] INSN_SDR2  = 16'hA030;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADD   = 3'd2,
    S_SHH   = 3'd3,
    S_SHL   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WORD_SIZE-1:0] a;
  logic [WORD_SIZE-1:0] hi;
  logic [WORD_SIZE-1:0] lo;
  logic [CNT_W-1:0]     cnt;
  logic                 c;
  logic                 hb;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = i_start ? S_CHECK : S_IDLE;
      // The ALU returns lo[0] replicated, so bit 0 is the current multiplier bit.
      S_CHECK: state_nxt = i_alu_result[0] ? S_ADD : S_SHH;
      S_ADD:   state_nxt = S_SHH;
      S_SHH:   state_nxt = S_SHL;
      S_SHL:   state_nxt = (cnt == '0) ? S_DONE : S_CHECK;
      S_DONE:  state_nxt = i_start ? S_CHECK : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers: operand load, accumulate, and the two half-shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
      c   <= 1'b0;
      hb  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            a   <= i_a;
            lo  <= i_b;
            hi  <= '0;
            cnt <= CNT_W'(WORD_SIZE - 1);
          end
        end
        S_CHECK: c <= 1'b0;
        S_ADD: begin
          hi <= i_alu_result;
          // A wrapped sum is smaller than either addend. That is the lost carry-out.
          c  <= (i_alu_result < hi);
        end
        S_SHH: begin
          hb <= hi[0];
          hi <= i_alu_result;
        end
        S_SHL: begin
          lo <= i_alu_result;
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: ALU bus drive and status, all derived from registered state
  always_comb begin
    o_alu_insn   = INSN_NOP;
    o_alu_r1data = '0;
    o_alu_r2data = '0;
    o_alu_carry  = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (state)
      S_CHECK: begin
        o_alu_insn   = INSN_CHECK;
        o_alu_r2data = lo;
        o_busy       = 1'b1;
      end
      S_ADD: begin
        o_alu_insn   = INSN_ADD;
        o_alu_r1data = hi;
        o_alu_r2data = a;
        o_busy       = 1'b1;
      end
      S_SHH: begin
        o_alu_insn   = INSN_SDR2;
        o_alu_r2data = hi;
        o_alu_carry  = c;
        o_busy       = 1'b1;
      end
      S_SHL: begin
        o_alu_insn   = INSN_SDR2;
        o_alu_r2data = lo;
        o_alu_carry  = hb;
        o_busy       = 1'b1;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_prod_hi = hi;
  assign o_prod_lo = lo;

endmodule

// File: tb/tb_lc4_mul_seq.sv
// Testbench for lc4_mul_seq. It contains a behavioural model of the lc4 ALU.
// Each directed operation pushes its hand-computed product, busy-cycle count
// and ADD count into a scoreboard queue. A monitor process pops and compares
// whenever o_done pulses.
module tb_lc4_mul_seq;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic [W-1:0]  i_a;
  logic [W-1:0]  i_b;
  logic          o_busy;
  logic          o_done;
  logic [W-1:0]  o_prod_hi;
  logic [W-1:0]  o_prod_lo;
  logic [15:0]   o_alu_insn;
  logic [W-1:0]  o_alu_r1data;
  logic [W-1:0]  o_alu_r2data;
  logic          o_alu_carry;
  logic [W-1:0]  alu_result;

  typedef struct {
    logic [31:0] prod;
    int          busy;
    int          adds;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;
  int   add_cnt = 0;

  lc4_mul_seq #(.WORD_SIZE(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_prod_hi    (o_prod_hi),
    .o_prod_lo    (o_prod_lo),
    .o_alu_insn   (o_alu_insn),
    .o_alu_r1data (o_alu_r1data),
    .o_alu_r2data (o_alu_r2data),
    .o_alu_carry  (o_alu_carry),
    .i_alu_result (alu_result)
  );

  // Behavioural lc4 ALU subset
  always_comb begin
    case (o_alu_insn)
      16'h1008: alu_result = {W{o_alu_r2data[0]}};
      16'h1000: alu_result = o_alu_r1data + o_alu_r2data;
      16'hA030: alu_result = {o_alu_carry, o_alu_r2data[W-1:1]};
      default:  alu_result = '0;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and ADD issues, and checks the bus is idle
  // outside busy states. It compares the scoreboard entry on each o_done.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy_cnt = 0;
        add_cnt  = 0;
      end else begin
        if (o_busy) busy_cnt++;
        if (o_alu_insn == 16'h1000) add_cnt++;
        if (!o_busy)
          chk("alu_idle", {15'd0, o_alu_carry, o_alu_insn | o_alu_r1data | o_alu_r2data}, 32'd0);
        if (o_done) begin
          if (sb_q.size() == 0) begin
            chk("done_unexpected", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("product", {o_prod_hi, o_prod_lo}, e.prod);
            chk("busy_cycles", busy_cnt, e.busy);
            chk("add_count", add_cnt, e.adds);
          end
          busy_cnt = 0;
          add_cnt  = 0;
        end
      end
    end
  end

  // Issue a start with the expected result; returns #2 after the accept edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [31:0] prod, input int busy, input int adds);
    exp_t e;
    e.prod = prod;
    e.busy = busy;
    e.adds = adds;
    sb_q.push_back(e);
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    @(posedge clk);
    #2;
    i_start = 1'b0;
  endtask

  // Bounded wait for o_done; returns #2 after the edge that entered DONE
  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_timeout", {31'd0, got}, 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_a     = '0;
    i_b     = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    chk("rst_prod", {o_prod_hi, o_prod_lo}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Basic 3x5
    start_op(16'd3, 16'd5, 32'h0000_000F, 50, 2);
    wait_done();

    // All ones: the ADD carry must reach hi via SDR2
    start_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 64, 16);
    wait_done();
    @(posedge clk);
    #2;
    chk("prod_hold", {o_prod_hi, o_prod_lo}, 32'hFFFE_0001);
    chk("done_one_cycle", {31'd0, o_done}, 32'd0);

    // b = 0: no ADD at all
    start_op(16'h1234, 16'h0000, 32'h0000_0000, 48, 0);
    wait_done();

    // MSB x MSB
    start_op(16'h8000, 16'h8000, 32'h4000_0000, 49, 1);
    wait_done();

    // Instruction trace for 7x1
    start_op(16'd7, 16'd1, 32'h0000_0007, 49, 1);
    chk("trace0", {16'd0, o_alu_insn}, 32'h0000_1008);
    @(posedge clk); #2;
    chk("trace1", {16'd0, o_alu_insn}, 32'h0000_1000);
    @(posedge clk); #2;
    chk("trace2", {16'd0, o_alu_insn}, 32'h0000_A030);
    @(posedge clk); #2;
    chk("trace3", {16'd0, o_alu_insn}, 32'h0000_A030);
    @(posedge clk); #2;
    chk("trace4", {16'd0, o_alu_insn}, 32'h0000_1008);
    wait_done();

    // A start while busy, with new operands, must be ignored
    start_op(16'd100, 16'd200, 32'h0000_4E20, 51, 3);
    repeat (10) @(posedge clk);
    #2;
    i_start = 1'b1;
    i_a     = 16'hFFFF;
    i_b     = 16'hFFFF;
    @(posedge clk);
    #2;
    i_start = 1'b0;
    wait_done();
    // Back-to-back start in the DONE cycle
    start_op(16'd9, 16'd11, 32'h0000_0063, 51, 3);
    chk("b2b_check", {15'd0, o_busy, o_alu_insn}, 32'h0001_1008);
    wait_done();

    // Mid-operation reset aborts immediately
    start_op(16'd3, 16'd5, 32'h0000_000F, 50, 2);
    repeat (18) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy_done", {30'd0, o_busy, o_done}, 32'd0);
    chk("abort_prod", {o_prod_hi, o_prod_lo}, 32'd0);
    chk("abort_alu", {15'd0, o_alu_carry, o_alu_insn | o_alu_r1data | o_alu_r2data}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    start_op(16'd2, 16'd2, 32'h0000_0004, 49, 1);
    wait_done();

    repeat (3) @(posedge clk);
    #2;
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
